// File: rtl/ros2_sub_msg_stream.sv
// rtl/ros2_sub_msg_stream.sv - subscriber message RAM replayed as a byte stream
// Locks the buffer via req/grant/rel on each received message and streams it out with last.
module ros2_sub_msg_stream #(
  parameter int MAX_LEN = 64,
  parameter int AW      = $clog2(MAX_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] sub_addr,
  input  logic          sub_ce,
  input  logic          sub_we,
  input  logic [7:0]    sub_wdata,
  input  logic [7:0]    sub_len,
  input  logic          sub_recv,
  output logic          sub_req,
  input  logic          sub_grant,
  output logic          sub_rel,
  output logic [7:0]    m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic          busy,
  output logic [15:0]   drop_cnt
);

  localparam int LW = AW + 1;

  typedef enum logic [2:0] {IDLE, REQ, RD, OUT, REL} state_t;

  state_t        state;
  logic [7:0]    mem [MAX_LEN];
  logic [LW-1:0] len;
  logic [LW-1:0] idx;
  logic [LW-1:0] idx_inc;

  assign idx_inc = idx + LW'(1);

  // Subscriber write port stays live in every state; contents are never reset.
  always_ff @(posedge clk) begin
    if (sub_ce && sub_we) mem[sub_addr] <= sub_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sub_req  <= 1'b0;
      sub_rel  <= 1'b0;
      m_data   <= 8'h00;
      m_valid  <= 1'b0;
      m_last   <= 1'b0;
      busy     <= 1'b0;
      drop_cnt <= 16'h0000;
      len      <= '0;
      idx      <= '0;
    end else begin
      sub_rel <= 1'b0;
      if (sub_recv && busy && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      case (state)
        IDLE: begin
          if (sub_recv) begin
            state   <= REQ;
            sub_req <= 1'b1;
            busy    <= 1'b1;
          end
        end
        REQ: begin
          if (sub_grant) begin
            sub_req <= 1'b0;
            idx     <= '0;
            // Clamp so an oversized length can never wrap the read address.
            len     <= (32'(sub_len) > MAX_LEN) ? LW'(MAX_LEN) : LW'(sub_len);
            if (sub_len == 8'd0) begin
              state   <= REL;
              sub_rel <= 1'b1;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          m_data  <= mem[idx[AW-1:0]];
          m_valid <= 1'b1;
          m_last  <= (idx_inc == len);
          state   <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            if (m_last) begin
              state   <= REL;
              sub_rel <= 1'b1;
            end else begin
              idx   <= idx_inc;
              state <= RD;
            end
          end
        end
        REL: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ros2_sub_msg_stream.sv
// tb/tb_ros2_sub_msg_stream.sv - table-driven scoreboard bench for ros2_sub_msg_stream
module tb_ros2_sub_msg_stream;

  localparam int MAX_LEN = 64;
  localparam int AW      = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] sub_addr = '0;
  logic          sub_ce = 1'b0;
  logic          sub_we = 1'b0;
  logic [7:0]    sub_wdata = 8'h00;
  logic [7:0]    sub_len = 8'h00;
  logic          sub_recv = 1'b0;
  logic          sub_req;
  logic          sub_grant = 1'b0;
  logic          sub_rel;
  logic [7:0]    m_data;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic          m_last;
  logic          busy;
  logic [15:0]   drop_cnt;

  ros2_sub_msg_stream #(.MAX_LEN(MAX_LEN), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .sub_addr(sub_addr), .sub_ce(sub_ce), .sub_we(sub_we), .sub_wdata(sub_wdata),
    .sub_len(sub_len), .sub_recv(sub_recv),
    .sub_req(sub_req), .sub_grant(sub_grant), .sub_rel(sub_rel),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct {
    int len;
    bit bp;
    bit gdrop;
    int extra;
    int exp_beats;
  } vec_t;

  beat_t      sb[$];
  beat_t      b;
  logic [7:0] mem_model [MAX_LEN];
  int total = 0, bad = 0;
  int cyc = 0;
  int beats, rel_count, first_valid, rel_cyc, last_hs;
  int exp_drop = 0;
  bit bp_mode = 1'b0;
  int pidx = 0;
  logic [3:0] pat = 4'b1001;
  bit stall = 1'b0, rel_prev = 1'b0;
  logic [7:0] h_data;
  logic h_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk);
    #1;
    m_ready = bp_mode ? pat[pidx] : 1'b1;
    pidx = (pidx + 1) % 4;
  end

  // Output monitor: pops the scoreboard on every handshake and checks hold stability.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (rel_prev) chk("busy_fall", busy, 0);
      if (sub_rel) begin
        rel_count++;
        rel_cyc = cyc;
        chk("busy_in_rel", busy, 1);
      end
      rel_prev = sub_rel;
      if (stall) chk("hold_stable", {m_valid, m_last, m_data}, {1'b1, h_last, h_data});
      if (m_valid) begin
        if (first_valid < 0) first_valid = cyc;
        if (m_ready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_beat: got data %0h with empty scoreboard", m_data);
          end else begin
            b = sb.pop_front();
            chk("beat_data", m_data, b.data);
            chk("beat_last", m_last, b.last);
          end
          beats++;
          last_hs = cyc;
        end
      end
      stall  = m_valid && !m_ready;
      h_data = m_data;
      h_last = m_last;
    end else begin
      stall    = 1'b0;
      rel_prev = 1'b0;
    end
  end

  task automatic write_byte(input int a, input logic [7:0] d, input logic ce, input logic we);
    @(posedge clk);
    #1;
    sub_addr  = AW'(a);
    sub_wdata = d;
    sub_ce    = ce;
    sub_we    = we;
    if (ce && we) mem_model[a] = d;
    @(posedge clk);
    #1;
    sub_ce = 1'b0;
    sub_we = 1'b0;
  endtask

  task automatic wait_req(input int r);
    int k;
    k = 0;
    while (!sub_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("req_latency", cyc, r + 1);
  endtask

  task automatic run_msg(input vec_t v);
    int n, r, g, k;
    n = (v.len > MAX_LEN) ? MAX_LEN : v.len;
    for (int i = 0; i < n; i++) sb.push_back('{data: mem_model[i], last: (i == n - 1)});
    beats = 0; rel_count = 0; first_valid = -1; rel_cyc = -1; last_hs = -1;
    bp_mode = v.bp;
    sub_len = 8'(v.len);
    @(posedge clk);
    #1;
    sub_recv = 1'b1;
    r = cyc;
    @(posedge clk);
    #1;
    sub_recv = 1'b0;
    wait_req(r);
    repeat (3) @(posedge clk);
    #1;
    sub_grant = 1'b1;
    g = cyc;
    @(posedge clk);
    #1;
    if (v.gdrop) sub_grant = 1'b0;
    @(negedge clk);
    chk("req_drop", sub_req, 0);
    for (int e = 0; e < v.extra; e++) begin
      @(posedge clk);
      #1;
      sub_recv = 1'b1;
      exp_drop++;
      @(posedge clk);
      #1;
      sub_recv = 1'b0;
    end
    k = 0;
    while (rel_count == 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    #1;
    sub_grant = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("beats", beats, v.exp_beats);
    chk("rel_pulses", rel_count, 1);
    chk("idle_after", {busy, sub_req, m_valid}, 0);
    chk("sb_empty", sb.size(), 0);
    chk("drop_cnt", drop_cnt, exp_drop);
    if (v.exp_beats > 0) begin
      chk("first_valid", first_valid, g + 2);
      chk("rel_after_last", rel_cyc, last_hs + 1);
    end else begin
      chk("no_valid", first_valid, -1);
      chk("rel_zero", rel_cyc, g + 1);
    end
  endtask

  initial begin
    vec_t vt[7];
    logic [7:0] hello[5];
    int r, k;
    vt[0] = '{5,   1'b0, 1'b0, 0, 5};
    vt[1] = '{5,   1'b1, 1'b0, 0, 5};
    vt[2] = '{0,   1'b0, 1'b0, 0, 0};
    vt[3] = '{200, 1'b0, 1'b0, 0, 64};
    vt[4] = '{5,   1'b1, 1'b1, 3, 5};
    vt[5] = '{1,   1'b1, 1'b0, 0, 1};
    vt[6] = '{64,  1'b1, 1'b0, 0, 64};
    hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {sub_req, sub_rel, m_valid, m_last, busy, m_data, drop_cnt}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < MAX_LEN; i++) write_byte(i, 8'(i * 37 + 11), 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) write_byte(i, hello[i], 1'b1, 1'b1);
    write_byte(0, 8'hEE, 1'b1, 1'b0);
    write_byte(1, 8'hEE, 1'b0, 1'b1);

    for (int t = 0; t < 7; t++) run_msg(vt[t]);

    // Saturation: hold recv while stuck in REQ so every cycle after the first is a drop.
    bp_mode = 1'b0;
    sub_len = 8'd0;
    @(posedge clk);
    #1;
    sub_recv = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    sub_recv = 1'b0;
    @(negedge clk);
    chk("drop_sat", drop_cnt, 16'hFFFF);
    chk("req_held", sub_req, 1);
    @(posedge clk);
    #1;
    sub_grant = 1'b1;
    @(posedge clk);
    #1;
    sub_grant = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("sat_idle", {busy, drop_cnt}, {1'b0, 16'hFFFF});

    // Reset during the second beat.
    sb.delete();
    for (int i = 0; i < 5; i++) sb.push_back('{data: mem_model[i], last: (i == 4)});
    beats = 0; rel_count = 0; first_valid = -1;
    sub_len = 8'd5;
    @(posedge clk);
    #1;
    sub_recv = 1'b1;
    r = cyc;
    @(posedge clk);
    #1;
    sub_recv = 1'b0;
    wait_req(r);
    repeat (3) @(posedge clk);
    #1;
    sub_grant = 1'b1;
    k = 0;
    while (!(beats == 1 && m_valid) && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("beat2_reached", beats, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outs", {sub_req, sub_rel, m_valid, m_last, busy, m_data, drop_cnt}, 0);
    sb.delete();
    exp_drop = 0;
    rel_count = 0;
    sub_grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("no_rel_after_reset", {rel_count[3:0], busy, sub_req}, 0);
    run_msg(vt[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ros2_sub_msg_stream.md
# ros2_sub_msg_stream

Downstream consumer of the ROS2 subscriber application-data port. It owns the received-message RAM that the subscriber core writes through the addr/ce/we/wdata port. On each completed message (`recv`) it locks the buffer through the req/grant/rel handshake and replays the bytes as an 8-bit valid/ready stream with `last`, then releases the buffer. It replaces the ad-hoc register array in board top levels and feeds UART bridges, LED decoders or user logic.

## Interface

Parameters:
- `MAX_LEN`, default 64: message buffer depth in bytes; equals `ROS2_MAX_APP_DATA_LEN`.
- `AW`, default `$clog2(MAX_LEN)`: RAM address width.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst_n`  in  1  reset; **asynchronous, active-low**.
- `sub_addr`  in  AW  RAM write address from the subscriber core.
- `sub_ce`  in  1  RAM chip enable.
- `sub_we`  in  1  RAM write enable; a write occurs when `sub_ce & sub_we`.
- `sub_wdata`  in  8  RAM write data.
- `sub_len`  in  8  length in bytes of the last received message.
- `sub_recv`  in  1  one-cycle pulse: a new message is complete.
- `sub_req`  out  1  level; requests buffer ownership.
- `sub_grant`  in  1  level; the block owns the buffer while high.
- `sub_rel`  out  1  one-cycle pulse; releases ownership.
- `m_data`  out  8  stream byte.
- `m_valid`  out  1  stream valid.
- `m_ready`  in  1  stream ready.
- `m_last`  out  1  marks the final byte of the message.
- `busy`  out  1  high in any state other than IDLE.
- `drop_cnt`  out  16  saturating count of `sub_recv` pulses that were ignored.

## Operation

- **RAM:** `MAX_LEN`×8, one synchronous write port (subscriber side) and one synchronous read port (block side).
  - Read latency is 1 cycle.
  - A read and a write to the same address in the same cycle returns the old data.
  - Writes are accepted in every state.
- **FSM states:** IDLE, REQ, RD, OUT, REL.
- **IDLE:** on `sub_recv`, go to REQ.
- **REQ:** hold `sub_req`=1.
  - When `sub_grant` is sampled high, latch `len = min(sub_len, MAX_LEN)` and clear the index `idx`.
  - If `len`==0, go to REL. Otherwise go to RD.
- **RD:** drive read address `idx`, then go to OUT.
- **OUT:** on the entry edge, register RAM data into `m_data`. Set `m_valid`=1 and `m_last=(idx==len-1)`.
  - Hold `m_data`, `m_valid` and `m_last` stable until `m_valid & m_ready`.
  - On that handshake: if `m_last`, go to REL; otherwise increment `idx` and go to RD.
- **REL:** `sub_rel`=1 for exactly one cycle, then go to IDLE.
- **Dropped receives:** a `sub_recv` pulse while `busy` increments `drop_cnt`.
  - The counter saturates at 0xFFFF.
  - The pulse is not queued.
- `sub_req` is deasserted in the cycle after grant is sampled. `sub_grant` dropping while in RD/OUT does not abort the transfer.
- Width rules:
  - `idx` is AW+1 bits.
  - `len` is compared after zero-extension.
  - `sub_len` > `MAX_LEN` is clamped and never wraps the address.

## Timing

- **Reset:** `sub_req`, `sub_rel`, `m_valid`, `m_last`, `busy` = 0; `m_data` = 0x00; `drop_cnt` = 0; FSM = IDLE.
  - RAM contents are not reset.
  - Reset mid-transfer abandons it without a `sub_rel` pulse; the subscriber core shares the same reset.
- **Handshake latency:** `sub_recv` at cycle 0 gives `sub_req`=1 at cycle 1.
- **First byte:** with grant sampled at cycle k, the first `m_valid` is at cycle k+2.
- **Throughput:** 1 byte per 2 cycles with `m_ready` held high. An N-byte message occupies the stream for 2N−1 cycles.
- **Release timing:**
  - `sub_rel` is asserted in the cycle after the last handshake.
  - `busy` falls the cycle after that.
  - A `sub_recv` in the same cycle `busy` falls is still counted as dropped. The next accepted `sub_recv` is the first one with `busy`=0.
- **Zero length:** `len`==0 produces no beats; grant is followed 1 cycle later by the `sub_rel` pulse.
- **Backpressure:** `m_ready` low for any number of cycles holds the current beat; no byte is lost or duplicated.

## Test plan

- **Basic message:** write "hello" to addr 0..4, `sub_len`=5, pulse `sub_recv`, grant 3 cycles after `sub_req`, `m_ready`=1.
  - Required: bytes 0x68,0x65,0x6C,0x6C,0x6F; `m_last` only on 0x6F.
  - Required: first valid 2 cycles after grant sampled; one `sub_rel` pulse; `busy` returns to 0.
- **Backpressure:** same message with `m_ready` toggling 1,0,0,1 periodically.
  - Required: identical 5-byte sequence; `m_data` stable while valid and not ready.
- **Zero length:** `sub_len`=0 with grant.
  - Required: no `m_valid`; `sub_rel` 1 cycle after grant sampled.
- **Clamp:** `sub_len`=200 with `MAX_LEN`=64.
  - Required: exactly 64 beats from addr 0..63; `m_last` on beat 64.
- **Dropped receives:** 3 `sub_recv` pulses while streaming.
  - Required: `drop_cnt`=3 and no extra transfer.
  - With `drop_cnt` preloaded by 65537 pulses, `drop_cnt` stays at 0xFFFF.
- **Reset mid-transfer:** assert `rst_n`=0 during beat 2.
  - Required: all outputs 0 immediately; FSM IDLE; no `sub_rel`.
  - Required: a new `sub_recv` after reset streams correctly from byte 0.
